// File: rtl/and3_deserializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : and3_deserializer_if                                      |
// | Brief    : Serial-in / word-out handshake bundle for and3_deserializer|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface and3_deserializer_if #(
  parameter int WIDTH = 3
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             sin_valid;
  logic             sin_data;
  logic             sin_ready;
  logic             pout_valid;
  logic [WIDTH-1:0] pout_data;
  logic             pout_all;
  logic             pout_ready;
  logic [CNT_W-1:0] bit_cnt;
`ifdef AND3_DESER_PARITY_EN
  logic             pout_perr;
`endif

  // master drives the serial source and consumes the words
  modport master (
`ifdef AND3_DESER_PARITY_EN
    input  pout_perr,
`endif
    output sin_valid, sin_data, pout_ready,
    input  sin_ready, pout_valid, pout_data, pout_all, bit_cnt
  );

  modport slave (
`ifdef AND3_DESER_PARITY_EN
    output pout_perr,
`endif
    input  sin_valid, sin_data, pout_ready,
    output sin_ready, pout_valid, pout_data, pout_all, bit_cnt
  );
endinterface
`default_nettype wire

// File: rtl/and3_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : and3_deserializer                                         |
// | Brief    : MSB-first serial-to-parallel receiver with AND-reduction. |
// |            Optional even parity: define AND3_DESER_PARITY_EN.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module and3_deserializer #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  and3_deserializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef AND3_DESER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             pout_valid_q, pout_valid_d;
  logic [WIDTH-1:0] pout_data_q, pout_data_d;
  logic             pout_all_q, pout_all_d;
`ifdef AND3_DESER_PARITY_EN
  logic             perr_q, perr_d;
`endif
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] word;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    pout_valid_d = pout_valid_q;
    pout_data_d  = pout_data_q;
    pout_all_d   = pout_all_q;
`ifdef AND3_DESER_PARITY_EN
    perr_d       = perr_q;
    word         = shift_q;
`else
    word         = {shift_q[WIDTH-2:0], bus.sin_data};
`endif
    ready  = (state_q == COLLECT) | bus.pout_ready;
    accept = bus.sin_valid & ready;

    if (state_q == HOLD && bus.pout_ready) begin
      state_d      = COLLECT;
      pout_valid_d = 1'b0;
    end

    // bit_cnt is always 0 in HOLD, so the zero-bubble bit can never complete a word
    if (accept) begin
      if (bit_cnt_q == LAST_CNT) begin
        state_d      = HOLD;
        pout_valid_d = 1'b1;
        pout_data_d  = word;
        pout_all_d   = &word;
        bit_cnt_d    = '0;
`ifdef AND3_DESER_PARITY_EN
        perr_d       = (^shift_q) ^ bus.sin_data;
`else
        shift_d      = word;
`endif
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        shift_d   = {shift_q[WIDTH-2:0], bus.sin_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      pout_valid_q <= 1'b0;
      pout_data_q  <= '0;
      pout_all_q   <= 1'b0;
`ifdef AND3_DESER_PARITY_EN
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      pout_valid_q <= pout_valid_d;
      pout_data_q  <= pout_data_d;
      pout_all_q   <= pout_all_d;
`ifdef AND3_DESER_PARITY_EN
      perr_q       <= perr_d;
`endif
    end
  end

  assign bus.sin_ready  = ready;
  assign bus.pout_valid = pout_valid_q;
  assign bus.pout_data  = pout_data_q;
  assign bus.pout_all   = pout_all_q;
  assign bus.bit_cnt    = bit_cnt_q;
`ifdef AND3_DESER_PARITY_EN
  assign bus.pout_perr  = perr_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_and3_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_and3_deserializer                                      |
// | Brief    : Self-checking bench: vector table, directed sequences and |
// |            randomized traffic against a queue-based word model.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_and3_deserializer;
  localparam int W = 3;
`ifdef AND3_DESER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  and3_deserializer_if #(.WIDTH(W)) bus ();
  and3_deserializer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  // model: accepted bits of the word in progress, plus the word on offer
  bit           m_hold;
  logic [W-1:0] m_word;
  bit           m_perr;
  int           m_bits[$];

  typedef struct {
    bit           sv, sd, pr, rdy, v;
    logic [W-1:0] d;
    bit           all;
    int           cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("pout_valid", 32'(bus.pout_valid), 32'(m_hold));
    chk("bit_cnt", 32'(bus.bit_cnt), 32'(m_bits.size()));
    if (m_hold) begin
      chk("pout_data", 32'(bus.pout_data), 32'(m_word));
      chk("pout_all", 32'(bus.pout_all), 32'(&m_word));
`ifdef AND3_DESER_PARITY_EN
      chk("pout_perr", 32'(bus.pout_perr), 32'(m_perr));
`endif
    end
  endtask

  task automatic cyc(input bit sv, input bit sd, input bit pr);
    bit rdy;
    bus.sin_valid  = sv;
    bus.sin_data   = sd;
    bus.pout_ready = pr;
    #1;
    rdy = !m_hold || pr;
    chk("sin_ready", 32'(bus.sin_ready), 32'(rdy));
    @(posedge clk);
    if (m_hold && pr) m_hold = 1'b0;
    if (sv && rdy) m_bits.push_back(int'(sd));
    if (m_bits.size() == NB) begin
      m_perr = 1'b0;
      for (int i = 0; i < NB; i++) m_perr = m_perr ^ m_bits[i][0];
      for (int i = 0; i < W; i++) m_word[W-1-i] = m_bits[i][0];
      m_hold = 1'b1;
      m_bits.delete();
    end
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.sin_valid  = 1'b1;
    bus.sin_data   = 1'b1;
    bus.pout_ready = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_hold = 1'b0;
    m_bits.delete();
    chk("rst_valid", 32'(bus.pout_valid), 32'd0);
    chk("rst_cnt", 32'(bus.bit_cnt), 32'd0);
    chk("rst_data", 32'(bus.pout_data), 32'd0);
    chk("rst_all", 32'(bus.pout_all), 32'd0);
`ifdef AND3_DESER_PARITY_EN
    chk("rst_perr", 32'(bus.pout_perr), 32'd0);
`endif
  endtask

  initial begin
    vec_t tbl[10];
    bit   alls[$];
    logic [8:0] pat;

    bus.sin_valid  = 1'b0;
    bus.sin_data   = 1'b0;
    bus.pout_ready = 1'b0;
    do_reset();

`ifndef AND3_DESER_PARITY_EN
    //          sv sd pr rdy v  data  all cnt
    tbl[0] = '{1, 1, 1, 1, 0, 3'b000, 0, 1};
    tbl[1] = '{1, 1, 1, 1, 0, 3'b000, 0, 2};
    tbl[2] = '{1, 1, 1, 1, 1, 3'b111, 1, 0};
    tbl[3] = '{0, 0, 1, 1, 0, 3'b000, 0, 0};
    tbl[4] = '{1, 1, 0, 1, 0, 3'b000, 0, 1};
    tbl[5] = '{1, 0, 1, 1, 0, 3'b000, 0, 2};
    tbl[6] = '{1, 1, 1, 1, 1, 3'b101, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 1, 3'b101, 0, 0};
    tbl[8] = '{0, 0, 1, 1, 0, 3'b000, 0, 0};
    tbl[9] = '{0, 1, 0, 1, 0, 3'b000, 0, 0};
    for (int i = 0; i < 10; i++) begin
      bus.sin_valid  = tbl[i].sv;
      bus.sin_data   = tbl[i].sd;
      bus.pout_ready = tbl[i].pr;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(bus.sin_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(bus.pout_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.bit_cnt), 32'(tbl[i].cnt));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_data", i), 32'(bus.pout_data), 32'(tbl[i].d));
        chk($sformatf("tbl%0d_all", i), 32'(bus.pout_all), 32'(tbl[i].all));
      end
    end

    // backpressure on word 011 with a bit waiting, then zero-bubble release
    do_reset();
    cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 1, 1);
    chk("bp_word", 32'(bus.pout_data), 32'h3);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0);
      chk("bp_ready", 32'(bus.sin_ready), 32'd0);
      chk("bp_hold", 32'(bus.pout_data), 32'h3);
    end
    cyc(1, 1, 1);
    chk("bp_cnt", 32'(bus.bit_cnt), 32'd1);
    chk("bp_valid", 32'(bus.pout_valid), 32'd0);
    cyc(1, 1, 1); cyc(1, 1, 1);

    // reset mid-word discards the partial bits
    do_reset();
    cyc(1, 1, 1); cyc(1, 1, 1);
    do_reset();
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 1, 1);
    chk("midrst_word", 32'(bus.pout_data), 32'h1);

    // streaming 111 000 111
    do_reset();
    pat = 9'b111000111;
    for (int i = 0; i < 9; i++) begin
      cyc(1, pat[8-i], 1);
      if (bus.pout_valid) alls.push_back(bus.pout_all);
    end
    cyc(0, 0, 1);
    if (bus.pout_valid) alls.push_back(bus.pout_all);
    chk("stream_words", 32'(alls.size()), 32'd3);
    if (alls.size() >= 3) begin
      chk("stream_all0", 32'(alls[0]), 32'd1);
      chk("stream_all1", 32'(alls[1]), 32'd0);
      chk("stream_all2", 32'(alls[2]), 32'd1);
    end
`else
    // parity: 110 with parity 1 -> error; 110 with parity 0 -> clean
    do_reset();
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    chk("par_data", 32'(bus.pout_data), 32'h6);
    chk("par_perr1", 32'(bus.pout_perr), 32'd1);
    cyc(0, 0, 1);
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    chk("par_data2", 32'(bus.pout_data), 32'h6);
    chk("par_perr0", 32'(bus.pout_perr), 32'd0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(1'($urandom % 2), 1'($urandom % 2), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
